imm_scan_ctrl: RTL
==================

# imm_scan_ctrl

Raster-scan sequencer for the image masking pipeline. On a start request it walks every pixel address of the frame (or only the mask window), issues frame-buffer reads, and feeds the returned pixels with their coordinates and the latched mask offsets into the `imm` masker. It then writes the masker's result back to the frame buffer and signals completion. It sits between the frame-buffer RAM and the `imm` instance. It owns all addressing and handshaking, so `imm` stays a pure datapath.

## Interface
- `IMG_ROWS`, 240, frame height in pixels (≤256)
- `IMG_COLS`, 320, frame width in pixels (≤512)
- `clk`  in  1  single system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a masking pass; sampled only in IDLE
- `abort`  in  1  synchronous cancel of a running pass
- `mask_row_offset_in`  in  8  mask top row, latched on accepted start
- `mask_col_offset_in`  in  9  mask left column, latched on accepted start
- `rd_en`  out  1  frame-buffer read strobe
- `rd_row` / `rd_col`  out  8/9  read address
- `rd_data`  in  12  frame-buffer read data, valid exactly 1 cycle after `rd_en`
- `image_pixel`  out  12  to `imm`; combinational pass-through of `rd_data`
- `pixel_row` / `pixel_col`  out  8/9  to `imm`; read address delayed 1 cycle
- `mask_row_offset` / `mask_col_offset`  out  8/9  to `imm`; latched offsets
- `pixel_row_out` / `pixel_col_out` / `pixel_result`  in  8/9/12  from `imm`
- `wr_en`  out  1  frame-buffer write strobe
- `wr_row` / `wr_col` / `wr_data`  out  8/9/12  write address and data; combinational from `imm` outputs
- `busy`  out  1  pass in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, SCAN, DRAIN, FIN.
- IDLE: `start`=1 latches offsets, loads row/col counters with the scan origin, and moves to SCAN. `start` in any other state is ignored.
- SCAN: `rd_en`=1 every cycle at the current counters.
  - Column increments each cycle.
  - At the last column, column reloads to the scan's first column and row increments.
  - The cycle that reads the last pixel moves to DRAIN.
- Valid pipeline: 2-stage shift register `v[1:0]`. `v[0]` is `rd_en` delayed 1 cycle and marks valid `imm` inputs. `v[1]` marks valid `imm` outputs; `wr_en` = `v[1]`.
- DRAIN: no reads; stays until `v` is all zero after the final write, then moves to FIN.
- FIN: `done`=1 for one cycle, then IDLE.
- `busy`=1 in SCAN, DRAIN and FIN.
- `abort`=1 in SCAN or DRAIN: next state IDLE, `v` cleared, no `done`. Writes already issued are not undone. `abort` has priority over every other transition.
- Arithmetic: counters are unsigned at `pixel_row`/`pixel_col` width. Window end is computed one bit wider so it cannot wrap, then clipped to `IMG_ROWS-1`/`IMG_COLS-1`.
- Empty scan region (origin beyond the image): SCAN is skipped, IDLE→FIN directly, `done` pulses with zero reads and zero writes.

## Timing
- Reset values: all outputs 0, state IDLE, offsets 0, `v`=0.
- Start accepted at edge T: the first `rd_en` is in cycle T+1, `image_pixel` is valid in T+2, and the first `wr_en` is in T+3.
- Throughput: one pixel per cycle with no bubbles, including across row wrap.
- For N pixels in the region: the last `wr_en` is in cycle T+N+2 and `done` is in T+N+3. The next `start` can be accepted in T+N+4.
- Read/write coordinates match: `wr_row`/`wr_col` equal the `rd_row`/`rd_col` issued 2 cycles earlier.

## Configuration
- `IMM_WINDOW_SCAN_EN` defined: the scan covers only rows `[mask_row_offset, mask_row_offset+`MASK_WIDTH)` and cols `[mask_col_offset, mask_col_offset+`MASK_HEIGHT)`, clipped to the frame. Pixels outside the window are neither read nor written. N = clipped window area.
- Not defined: full-frame scan starting at (0,0), N = `IMG_ROWS`×`IMG_COLS`. Outside pixels are rewritten unchanged by `imm`.

## Test plan
- Full frame, `IMG_ROWS`=4, `IMG_COLS`=5, start at T=0 → 20 reads in T1–T20 in raster order with (0,4)→(1,0) wrap; `wr_en` in T3–T22 with matching coordinates; `done` only at T23.
- Window mode, offsets (1,2), mask 2×2, 4×5 frame → reads exactly (1,2),(1,3),(2,2),(2,3), back-to-back; 4 writes; `done` at T7.
- Window mode, offsets (3,4) on a 4×5 frame with a 2×2 mask → clipped to the single pixel (3,4); 1 write; `done` at T4.
- Window mode, offsets (10,0) on a 4-row frame → no `rd_en`/`wr_en`; `done` pulse in T+1.
- `abort` asserted during the 6th read → `rd_en` drops the next cycle, `wr_en` drops the next cycle, `busy`=0, no `done`; a following `start` runs a clean full pass.
- `rst_n` pulsed low mid-SCAN → all outputs 0 immediately; `start` pulsed during busy → ignored, and the pixel count stays at N.

Source files
------------

// File: rtl/imm_scan_ctrl.sv
// Raster-scan sequencer feeding the imm masker from the frame buffer and writing results back.
// Define IMM_WINDOW_SCAN_EN to restrict the scan to the clipped mask window (default: full frame).
`ifdef IMM_WINDOW_SCAN_EN
`ifndef MASK_WIDTH
`define MASK_WIDTH 2
`endif
`ifndef MASK_HEIGHT
`define MASK_HEIGHT 2
`endif
`endif

// state | meaning
// IDLE  | waiting for start
// SCAN  | one frame-buffer read per cycle
// DRAIN | reads done, flushing the read/imm pipeline
// FIN   | one-cycle done pulse
module imm_scan_ctrl #(
   parameter int IMG_ROWS = 240,
   parameter int IMG_COLS = 320
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [7:0]  mask_row_offset_in,
   input  logic [8:0]  mask_col_offset_in,
   output logic        rd_en,
   output logic [7:0]  rd_row,
   output logic [8:0]  rd_col,
   input  logic [11:0] rd_data,
   output logic [11:0] image_pixel,
   output logic [7:0]  pixel_row,
   output logic [8:0]  pixel_col,
   output logic [7:0]  mask_row_offset,
   output logic [8:0]  mask_col_offset,
   input  logic [7:0]  pixel_row_out,
   input  logic [8:0]  pixel_col_out,
   input  logic [11:0] pixel_result,
   output logic        wr_en,
   output logic [7:0]  wr_row,
   output logic [8:0]  wr_col,
   output logic [11:0] wr_data,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

   localparam logic [8:0] ROW_MAX = 9'(IMG_ROWS - 1);
   localparam logic [9:0] COL_MAX = 10'(IMG_COLS - 1);

   state_t      state_q, state_d;
   logic [7:0]  roff_q, roff_d, row_q, row_d, prow_q;
   logic [8:0]  coff_q, coff_d, col_q, col_d, pcol_q;
   logic [1:0]  v_q, v_d;
   logic [7:0]  row_org, row_last;
   logic [8:0]  col_org, col_first, col_last;
   logic        empty, accept, last_col, last_row, kill;

`ifdef IMM_WINDOW_SCAN_EN
   localparam logic [8:0] ROW_LIM = 9'(IMG_ROWS);
   localparam logic [9:0] COL_LIM = 10'(IMG_COLS);
   logic [8:0] row_end_w;
   logic [9:0] col_end_w;

   // window end is one bit wider so offset+size never wraps before clipping
   always_comb begin
      row_org   = mask_row_offset_in;
      col_org   = mask_col_offset_in;
      col_first = coff_q;
      row_end_w = {1'b0, roff_q} + 9'(`MASK_WIDTH - 1);
      col_end_w = {1'b0, coff_q} + 10'(`MASK_HEIGHT - 1);
      row_last  = (row_end_w > ROW_MAX) ? ROW_MAX[7:0] : row_end_w[7:0];
      col_last  = (col_end_w > COL_MAX) ? COL_MAX[8:0] : col_end_w[8:0];
      empty     = ({1'b0, row_org} >= ROW_LIM) || ({1'b0, col_org} >= COL_LIM);
   end
`else
   always_comb begin
      row_org   = '0;
      col_org   = '0;
      col_first = '0;
      row_last  = ROW_MAX[7:0];
      col_last  = COL_MAX[8:0];
      empty     = 1'b0;
   end
`endif

   assign accept   = (state_q == IDLE) && start;
   assign last_col = (col_q == col_last);
   assign last_row = (row_q == row_last);
   assign kill     = abort && ((state_q == SCAN) || (state_q == DRAIN));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (start) state_d = empty ? FIN : SCAN;
         SCAN:  if (abort) state_d = IDLE;
                else if (last_col && last_row) state_d = DRAIN;
         DRAIN: if (abort) state_d = IDLE;
                else if (!v_q[0]) state_d = FIN;
         FIN:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_en = (state_q == SCAN);
      busy  = (state_q != IDLE);
      done  = (state_q == FIN);
   end

   always_comb begin
      roff_d = roff_q;
      coff_d = coff_q;
      row_d  = row_q;
      col_d  = col_q;
      v_d    = kill ? 2'b00 : {v_q[0], rd_en};
      if (accept) begin
         roff_d = mask_row_offset_in;
         coff_d = mask_col_offset_in;
         row_d  = row_org;
         col_d  = col_org;
      end else if (rd_en && !abort) begin
         if (last_col) begin
            col_d = col_first;
            if (!last_row) row_d = row_q + 8'd1;
         end else begin
            col_d = col_q + 9'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         roff_q <= '0;
         coff_q <= '0;
         row_q  <= '0;
         col_q  <= '0;
         prow_q <= '0;
         pcol_q <= '0;
         v_q    <= '0;
      end else begin
         roff_q <= roff_d;
         coff_q <= coff_d;
         row_q  <= row_d;
         col_q  <= col_d;
         prow_q <= row_q;
         pcol_q <= col_q;
         v_q    <= v_d;
      end
   end

   // write bus is forced to zero outside valid imm outputs
   assign rd_row          = row_q;
   assign rd_col          = col_q;
   assign image_pixel     = rd_data;
   assign pixel_row       = prow_q;
   assign pixel_col       = pcol_q;
   assign mask_row_offset = roff_q;
   assign mask_col_offset = coff_q;
   assign wr_en           = v_q[1];
   assign wr_row          = v_q[1] ? pixel_row_out : '0;
   assign wr_col          = v_q[1] ? pixel_col_out : '0;
   assign wr_data         = v_q[1] ? pixel_result  : '0;

endmodule
